cartridge_bus_master: RTL and testbench

- CPU-side initiator for the cartridge bus. The cartridge responder samples this bus: address, bidirectional 8-bit data, active-low WE/RE strobes.
- Accepts single-beat read/write requests from the CPU core through a ready/valid handshake.
- Sequences each request through programmable setup/strobe/hold phases, captures read data, and reports completion with a one-cycle response pulse.
- Only block that drives cartridge-bus address and strobes; sits between the CPU memory arbiter and the cartridge responder.

---
 rtl/cartridge_bus_master.sv | 228 ++++++++++++++++++++++
 tb/tb_cartridge_bus_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cartridge_bus_master.sv
// Cartridge bus initiator: sequences single-beat CPU reads/writes through setup/strobe/hold phases.
// Optional bank-register shadowing of completed low-address writes is enabled by defining CART_BANK_SHADOW_EN.
module cartridge_bus_master #(
    parameter int P_SETUP_CYCLES  = 1,
    parameter int P_STROBE_CYCLES = 4,
    parameter int P_HOLD_CYCLES   = 1,
    parameter int P_CNT_W         = 4
) (
    input  logic        I_CLK,
    input  logic        I_RESET_L,
    input  logic        I_REQ,
    input  logic        I_REQ_WE,
    input  logic [15:0] I_REQ_ADDR,
    input  logic [7:0]  I_REQ_WDATA,
    output logic        O_REQ_READY,
    output logic        O_RSP_VALID,
    output logic [7:0]  O_RSP_RDATA,
    output logic [15:0] O_CARTRIDGE_ADDR,
    inout  wire  [7:0]  IO_CARTRIDGE_DATA,
    output logic        O_CARTRIDGE_WE_L,
    output logic        O_CARTRIDGE_RE_L,
    output logic        O_BUSY,
    output logic [6:0]  O_ROM_BANK,
    output logic [3:0]  O_RAM_BANK,
    output logic        O_RAM_EN
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int SETUP_N  = (P_SETUP_CYCLES > 0) ? P_SETUP_CYCLES - 1 : 0;
    localparam int STROBE_N = (P_STROBE_CYCLES > 0) ? P_STROBE_CYCLES - 1 : 0;
    localparam int HOLD_N   = (P_HOLD_CYCLES > 0) ? P_HOLD_CYCLES - 1 : 0;
    localparam logic [P_CNT_W-1:0] SETUP_LOAD  = P_CNT_W'(SETUP_N);
    localparam logic [P_CNT_W-1:0] STROBE_LOAD = P_CNT_W'(STROBE_N);
    localparam logic [P_CNT_W-1:0] HOLD_LOAD   = P_CNT_W'(HOLD_N);
    localparam logic [P_CNT_W-1:0] CNT_ZERO    = {P_CNT_W{1'b0}};
    localparam logic [P_CNT_W-1:0] CNT_ONE     = P_CNT_W'(1);

    state_t             state_q, state_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               we_l_q, we_l_d;
    logic               re_l_q, re_l_d;
    logic               drive_q, drive_d;
    logic               done_s;

    // Phase sequencing, request capture and next-cycle decode of all bus outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (I_REQ) begin
                    we_d    = I_REQ_WE;
                    addr_d  = I_REQ_ADDR;
                    wdata_d = I_REQ_WDATA;
                    if (P_SETUP_CYCLES > 0) begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                    end else begin
                        state_d = ST_STROBE;
                        cnt_d   = STROBE_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == CNT_ZERO) begin
                    // Responder data is valid while RE_L is still low in this last strobe cycle
                    if (!we_q) begin
                        rdata_d = IO_CARTRIDGE_DATA;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    if (P_HOLD_CYCLES > 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        done_s      = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        rsp_valid_d = done_s;
        ready_d     = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        we_l_d      = !((state_d == ST_STROBE) && we_d);
        re_l_d      = !((state_d == ST_STROBE) && !we_d);
        drive_d     = we_d && (state_d != ST_IDLE);
    end

    // State, datapath and registered bus outputs
    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            we_l_q      <= 1'b1;
            re_l_q      <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            we_l_q      <= we_l_d;
            re_l_q      <= re_l_d;
            drive_q     <= drive_d;
        end
    end

    assign IO_CARTRIDGE_DATA = drive_q ? wdata_q : 8'hzz;
    assign O_REQ_READY       = ready_q;
    assign O_RSP_VALID       = rsp_valid_q;
    assign O_RSP_RDATA       = rdata_q;
    assign O_CARTRIDGE_ADDR  = addr_q;
    assign O_CARTRIDGE_WE_L  = we_l_q;
    assign O_CARTRIDGE_RE_L  = re_l_q;
    assign O_BUSY            = busy_q;

`ifdef CART_BANK_SHADOW_EN
    logic [6:0] rom_bank_q, rom_bank_d;
    logic [3:0] ram_bank_q, ram_bank_d;
    logic       ram_en_q, ram_en_d;

    // Mirror mapper register writes; address[14:13] selects the register within the low 32 KiB
    always_comb begin
        rom_bank_d = rom_bank_q;
        ram_bank_d = ram_bank_q;
        ram_en_d   = ram_en_q;
        if (done_s && we_q && !addr_q[15]) begin
            case (addr_q[14:13])
                2'b00: begin
                    if (wdata_q == 8'h0A) begin
                        ram_en_d = 1'b1;
                    end else if (wdata_q == 8'h00) begin
                        ram_en_d = 1'b0;
                    end else begin
                        ram_en_d = ram_en_q;
                    end
                end
                2'b01: begin
                    rom_bank_d = (wdata_q[6:0] == 7'd0) ? 7'd1 : wdata_q[6:0];
                end
                2'b10: begin
                    ram_bank_d = wdata_q[3:0];
                end
                default: begin
                    rom_bank_d = rom_bank_q;
                end
            endcase
        end else begin
            ram_en_d = ram_en_q;
        end
    end

    // Shadow bank registers
    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            rom_bank_q <= 7'd1;
            ram_bank_q <= 4'd0;
            ram_en_q   <= 1'b0;
        end else begin
            rom_bank_q <= rom_bank_d;
            ram_bank_q <= ram_bank_d;
            ram_en_q   <= ram_en_d;
        end
    end

    assign O_ROM_BANK = rom_bank_q;
    assign O_RAM_BANK = ram_bank_q;
    assign O_RAM_EN   = ram_en_q;
`else
    assign O_ROM_BANK = 7'd1;
    assign O_RAM_BANK = 4'd0;
    assign O_RAM_EN   = 1'b0;
`endif

endmodule

// File: tb/tb_cartridge_bus_master.sv
// Self-checking bench for cartridge_bus_master: per-cycle strobe/bus checks plus a read-data scoreboard.
module tb_cartridge_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        ready, rsp_valid, we_l, re_l, busy, ram_en;
    logic [7:0]  rdata;
    logic [15:0] cart_addr;
    logic [6:0]  rom_bank;
    logic [3:0]  ram_bank;
    tri1  [7:0]  cart_data;
    logic [7:0]  resp_val = 8'h00;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_q[$];
    logic [7:0] model_rdata = 8'h00;

    // Responder drives read data only while the read strobe is low; otherwise the bus floats high
    assign cart_data = (re_l === 1'b0) ? resp_val : 8'hzz;

    always #5 clk = ~clk;

    cartridge_bus_master dut (
        .I_CLK            (clk),
        .I_RESET_L        (rst_n),
        .I_REQ            (req),
        .I_REQ_WE         (req_we),
        .I_REQ_ADDR       (req_addr),
        .I_REQ_WDATA      (req_wdata),
        .O_REQ_READY      (ready),
        .O_RSP_VALID      (rsp_valid),
        .O_RSP_RDATA      (rdata),
        .O_CARTRIDGE_ADDR (cart_addr),
        .IO_CARTRIDGE_DATA(cart_data),
        .O_CARTRIDGE_WE_L (we_l),
        .O_CARTRIDGE_RE_L (re_l),
        .O_BUSY           (busy),
        .O_ROM_BANK       (rom_bank),
        .O_RAM_BANK       (ram_bank),
        .O_RAM_EN         (ram_en)
    );

    // Drive one request and record the read data the response must carry
    task automatic send(input logic we, input logic [15:0] a, input logic [7:0] d, input logic [7:0] rsp);
        req       = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        resp_val  = rsp;
        if (we) begin
            sb_q.push_back(model_rdata);
        end else begin
            sb_q.push_back(rsp);
            model_rdata = rsp;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({re_l, we_l, busy, ready, rsp_valid} !== 5'b11010) begin
            errors++;
            $display("FAIL reset_ctl got %b exp %b", {re_l, we_l, busy, ready, rsp_valid}, 5'b11010);
        end
        checks++;
        if ({rdata, cart_addr, cart_data} !== {8'h00, 16'h0000, 8'hFF}) begin
            errors++;
            $display("FAIL reset_data rdata=%h addr=%h bus=%h exp 00 0000 ff", rdata, cart_addr, cart_data);
        end
        checks++;
        if ({rom_bank, ram_bank, ram_en} !== {7'd1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_shadow got %h/%h/%b exp 01/0/0", rom_bank, ram_bank, ram_en);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        logic [4:0] exp_ctl;
        logic [7:0] exp_bus;
        logic [7:0] exp_rd;
        int         nrsp = 0;
        @(negedge clk);
        send(1'b0, 16'h0134, 8'h00, 8'h4E);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req = 1'b0;
            exp_ctl = {!(c >= 2 && c <= 5), 1'b1, (c <= 6), (c >= 7), (c == 7)};
            exp_bus = (c >= 2 && c <= 5) ? 8'h4E : 8'hFF;
            checks++;
            if ({re_l, we_l, busy, ready, rsp_valid} !== exp_ctl) begin
                errors++;
                $display("FAIL read_ctl c=%0d got %b exp %b", c, {re_l, we_l, busy, ready, rsp_valid}, exp_ctl);
            end
            checks++;
            if (cart_data !== exp_bus || cart_addr !== 16'h0134) begin
                errors++;
                $display("FAIL read_bus c=%0d bus=%h addr=%h exp %h 0134", c, cart_data, cart_addr, exp_bus);
            end
            if (rsp_valid === 1'b1) begin
                nrsp++;
                exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                checks++;
                if (rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL read_rdata got %h exp %h", rdata, exp_rd);
                end
            end
        end
        checks++;
        if (nrsp != 1) begin
            errors++;
            $display("FAIL read_rsp_count got %0d exp 1", nrsp);
        end
    endtask

    task automatic test_write();
        logic [4:0] exp_ctl;
        logic [7:0] exp_bus;
        logic [7:0] exp_rd;
        int         nrsp = 0;
        @(negedge clk);
        send(1'b1, 16'hA010, 8'h5A, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req = 1'b0;
            exp_ctl = {1'b1, !(c >= 2 && c <= 5), (c <= 6), (c >= 7), (c == 7)};
            exp_bus = (c >= 1 && c <= 6) ? 8'h5A : 8'hFF;
            checks++;
            if ({re_l, we_l, busy, ready, rsp_valid} !== exp_ctl) begin
                errors++;
                $display("FAIL write_ctl c=%0d got %b exp %b", c, {re_l, we_l, busy, ready, rsp_valid}, exp_ctl);
            end
            checks++;
            if (cart_data !== exp_bus || cart_addr !== 16'hA010) begin
                errors++;
                $display("FAIL write_bus c=%0d bus=%h addr=%h exp %h a010", c, cart_data, cart_addr, exp_bus);
            end
            if (rsp_valid === 1'b1) begin
                nrsp++;
                exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                checks++;
                if (rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL write_rdata_kept got %h exp %h", rdata, exp_rd);
                end
            end
        end
        checks++;
        if (nrsp != 1) begin
            errors++;
            $display("FAIL write_rsp_count got %0d exp 1", nrsp);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_ctl;
        logic [7:0]  exp_bus;
        logic [15:0] exp_addr;
        logic [7:0]  exp_rd;
        int          nrsp = 0;
        @(negedge clk);
        send(1'b0, 16'h0200, 8'h00, 8'h33);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c != 7) begin
                req = 1'b0;
            end else begin
                req = req;
            end
            exp_ctl  = {!(c >= 2 && c <= 5), !(c >= 9 && c <= 12),
                        ((c <= 6) || (c >= 8 && c <= 13)), (c == 7 || c >= 14), (c == 7 || c == 14)};
            exp_bus  = (c >= 2 && c <= 5) ? 8'h33 : ((c >= 8 && c <= 13) ? 8'h77 : 8'hFF);
            exp_addr = (c <= 7) ? 16'h0200 : 16'h0300;
            checks++;
            if ({re_l, we_l, busy, ready, rsp_valid} !== exp_ctl) begin
                errors++;
                $display("FAIL b2b_ctl c=%0d got %b exp %b", c, {re_l, we_l, busy, ready, rsp_valid}, exp_ctl);
            end
            checks++;
            if (cart_data !== exp_bus || cart_addr !== exp_addr) begin
                errors++;
                $display("FAIL b2b_bus c=%0d bus=%h addr=%h exp %h %h", c, cart_data, cart_addr, exp_bus, exp_addr);
            end
            if (rsp_valid === 1'b1) begin
                nrsp++;
                exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                checks++;
                if (rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL b2b_rdata c=%0d got %h exp %h", c, rdata, exp_rd);
                end
            end
            // Second request is presented in the first response cycle
            if (c == 7) begin
                send(1'b1, 16'h0300, 8'h77, 8'h33);
            end
        end
        checks++;
        if (nrsp != 2) begin
            errors++;
            $display("FAIL b2b_rsp_count got %0d exp 2", nrsp);
        end
    endtask

    task automatic test_busy_ignore();
        logic [4:0] exp_ctl;
        logic [7:0] exp_rd;
        int         nrsp = 0;
        @(negedge clk);
        send(1'b0, 16'h1234, 8'h00, 8'h5C);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            exp_ctl = {!(c >= 2 && c <= 5), 1'b1, (c <= 6), (c >= 7), (c == 7)};
            checks++;
            if ({re_l, we_l, busy, ready, rsp_valid} !== exp_ctl) begin
                errors++;
                $display("FAIL busy_ctl c=%0d got %b exp %b", c, {re_l, we_l, busy, ready, rsp_valid}, exp_ctl);
            end
            checks++;
            if (cart_addr !== 16'h1234) begin
                errors++;
                $display("FAIL busy_addr c=%0d got %h exp 1234", c, cart_addr);
            end
            if (rsp_valid === 1'b1) begin
                nrsp++;
                exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                checks++;
                if (rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL busy_rdata got %h exp %h", rdata, exp_rd);
                end
            end
            if (c == 1) begin
                req_we    = 1'b1;
                req_addr  = 16'h4321;
                req_wdata = 8'hC6;
            end else if (c == 6) begin
                req = 1'b0;
            end else begin
                req = req;
            end
        end
        checks++;
        if (nrsp != 1) begin
            errors++;
            $display("FAIL busy_rsp_count got %0d exp 1", nrsp);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] dropped;
        @(negedge clk);
        send(1'b1, 16'h2000, 8'h05, 8'h00);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req = 1'b0;
        end
        checks++;
        if (we_l !== 1'b0 || cart_data !== 8'h05) begin
            errors++;
            $display("FAIL abort_pre we_l=%b bus=%h exp 0 05", we_l, cart_data);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({re_l, we_l, busy, ready, rsp_valid} !== 5'b11010) begin
            errors++;
            $display("FAIL abort_ctl got %b exp %b", {re_l, we_l, busy, ready, rsp_valid}, 5'b11010);
        end
        checks++;
        if (cart_data !== 8'hFF || rdata !== 8'h00) begin
            errors++;
            $display("FAIL abort_bus bus=%h rdata=%h exp ff 00", cart_data, rdata);
        end
        dropped = sb_q.pop_back();
        model_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, ready, rsp_valid, rom_bank} !== {1'b0, 1'b1, 1'b0, 7'd1}) begin
                errors++;
                $display("FAIL abort_after c=%0d busy/ready/valid=%b%b%b rom=%h exp 010 01 (dropped %h)",
                         c, busy, ready, rsp_valid, rom_bank, dropped);
            end
        end
    endtask

    task automatic test_shadow();
        logic [15:0] ta [6];
        logic [7:0]  td [6];
        logic [11:0] exp_sh [6];
        logic [11:0] prev;
        logic [7:0]  exp_rd;
        ta = '{16'h2000, 16'hA000, 16'h2000, 16'h0000, 16'h4000, 16'h6000};
        td = '{8'h05, 8'h00, 8'h00, 8'h0A, 8'h09, 8'h00};
`ifdef CART_BANK_SHADOW_EN
        exp_sh = '{{7'd5, 4'd0, 1'b0}, {7'd5, 4'd0, 1'b0}, {7'd1, 4'd0, 1'b0},
                   {7'd1, 4'd0, 1'b1}, {7'd1, 4'd9, 1'b1}, {7'd1, 4'd9, 1'b1}};
`else
        exp_sh = '{{7'd1, 4'd0, 1'b0}, {7'd1, 4'd0, 1'b0}, {7'd1, 4'd0, 1'b0},
                   {7'd1, 4'd0, 1'b0}, {7'd1, 4'd0, 1'b0}, {7'd1, 4'd0, 1'b0}};
`endif
        prev = {7'd1, 4'd0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            send(1'b1, ta[i], td[i], 8'h00);
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                req = 1'b0;
                if (c == 6) begin
                    checks++;
                    if ({rom_bank, ram_bank, ram_en} !== prev) begin
                        errors++;
                        $display("FAIL shadow_early i=%0d got %h exp %h", i, {rom_bank, ram_bank, ram_en}, prev);
                    end
                end
                if (c == 7) begin
                    checks++;
                    if (rsp_valid !== 1'b1 || {rom_bank, ram_bank, ram_en} !== exp_sh[i]) begin
                        errors++;
                        $display("FAIL shadow_upd i=%0d valid=%b got %h exp 1 %h", i, rsp_valid,
                                 {rom_bank, ram_bank, ram_en}, exp_sh[i]);
                    end
                    exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                    checks++;
                    if (rdata !== exp_rd) begin
                        errors++;
                        $display("FAIL shadow_rdata i=%0d got %h exp %h", i, rdata, exp_rd);
                    end
                end
            end
            prev = exp_sh[i];
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_shadow();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
